// File: rtl/rand_delay_mem_arbiter.sv
// Two-master memory arbiter with an LFSR-driven random wait before each access.
// One transaction in flight; sequences a single-port synchronous SRAM.
module rand_delay_mem_arbiter #(
  parameter int unsigned MAX_DELAY = 20,
  parameter bit          DELAY_EN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  seed,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [31:0] m1_rdata,

  output logic        mem_en,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] DELAY_MOD = LFSR_W'(MAX_DELAY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_d;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] cnt;
  logic              gnt_id;
  logic              last_grant;
  logic              wen_q;

  logic grant0_c;
  logic grant1_c;
  logic req_hs_c;
  logic resp_hs_c;

  // Round-robin: on a tie the master that did not win last time is granted.
  assign grant0_c  = (state == S_IDLE) && m0_req_valid && (!m1_req_valid || last_grant);
  assign grant1_c  = (state == S_IDLE) && m1_req_valid && (!m0_req_valid || !last_grant);
  assign req_hs_c  = grant0_c || grant1_c;
  assign resp_hs_c = gnt_id ? (m1_resp_valid && m1_resp_ready)
                            : (m0_resp_valid && m0_resp_ready);

  assign m0_req_ready = grant0_c;
  assign m1_req_ready = grant1_c;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (req_hs_c) state_d = S_DELAY;
      S_DELAY:  if (cnt == '0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DATA;
      S_DATA:   state_d = S_RESP;
      S_RESP:   if (resp_hs_c) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request latch, delay scheduler and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr          <= (seed == '0) ? LFSR_W'(1) : seed;
      cnt           <= '0;
      gnt_id        <= 1'b0;
      last_grant    <= 1'b1;
      wen_q         <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      mem_en        <= 1'b0;
      mem_wen       <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (req_hs_c) begin
        gnt_id     <= grant1_c;
        last_grant <= grant1_c;
        wen_q      <= grant1_c ? m1_wen   : m0_wen;
        mem_addr   <= grant1_c ? m1_addr  : m0_addr;
        mem_wdata  <= grant1_c ? m1_wdata : m0_wdata;
        mem_wmask  <= grant1_c ? m1_wmask : m0_wmask;
        cnt        <= DELAY_EN ? (lfsr % DELAY_MOD) : '0;
        lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else if ((state == S_DELAY) && (cnt != '0)) begin
        cnt <= cnt - LFSR_W'(1);
      end

      if (state == S_DATA) begin
        if (gnt_id) begin
          m1_rdata <= wen_q ? '0 : mem_rdata;
        end else begin
          m0_rdata <= wen_q ? '0 : mem_rdata;
        end
      end

      mem_en        <= (state_d == S_ACCESS);
      mem_wen       <= (state_d == S_ACCESS) && wen_q;
      m0_resp_valid <= (state_d == S_RESP) && !gnt_id;
      m1_resp_valid <= (state_d == S_RESP) && gnt_id;
      busy          <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_rand_delay_mem_arbiter.sv
// Self-checking bench: vector table, hand-written corner sequences and random
// traffic checked against a transaction-level model of delay and memory contents.
module tb_rand_delay_mem_arbiter;

  localparam int unsigned MAX_DELAY = 20;
  localparam bit          DELAY_EN  = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic        m0_req_ready, m1_req_ready;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_wen = 1'b0, m1_wen = 1'b0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_resp_valid, m1_resp_valid;
  logic        m0_resp_ready = 1'b0, m1_resp_ready = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        busy;

  rand_delay_mem_arbiter #(.MAX_DELAY(MAX_DELAY), .DELAY_EN(DELAY_EN)) dut (
    .clock(clock), .reset(reset), .seed(seed),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int viol = 0;

  // SRAM environment (read-before-write) and the bench's expected image of it.
  logic        fill = 1'b1;
  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  mlfsr;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0101_0103) ^ 32'hA5A5_5A5A;
  endfunction

  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) sram[i] <= pat(i);
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr[9:2]];
      if (mem_wen)
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  // Protocol monitor plus grant/response order capture for the round-robin test.
  bit rr_on = 1'b0;
  int gq[$];
  int rq[$];
  always @(negedge clock) begin
    #1;
    if (m0_req_ready && m1_req_ready) viol++;
    if (m0_resp_valid && m1_resp_valid) viol++;
    if (rr_on) begin
      if (m0_req_valid && m0_req_ready) gq.push_back(0);
      if (m1_req_valid && m1_req_ready) gq.push_back(1);
      if (m0_resp_valid && m0_resp_ready) rq.push_back(0);
      if (m1_resp_valid && m1_resp_ready) rq.push_back(1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int model_delay(input logic [7:0] v);
    return DELAY_EN ? (int'(v) % int'(MAX_DELAY + 1)) : 0;
  endfunction

  function automatic logic get_ready(input bit m);
    return m ? m1_req_ready : m0_req_ready;
  endfunction
  function automatic logic get_rvalid(input bit m);
    return m ? m1_resp_valid : m0_resp_valid;
  endfunction
  function automatic logic [31:0] get_rdata(input bit m);
    return m ? m1_rdata : m0_rdata;
  endfunction

  task automatic set_valid(input bit m, input logic v);
    if (m) m1_req_valid = v; else m0_req_valid = v;
  endtask
  task automatic set_rready(input bit m, input logic v);
    if (m) m1_resp_ready = v; else m0_resp_ready = v;
  endtask
  task automatic set_req(input bit m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] mk);
    if (m) begin
      m1_req_valid = 1'b1; m1_wen = w; m1_addr = a; m1_wdata = d; m1_wmask = mk;
    end else begin
      m0_req_valid = 1'b1; m0_wen = w; m0_addr = a; m0_wdata = d; m0_wmask = mk;
    end
  endtask

  task automatic apply_reset(input logic [7:0] s);
    @(negedge clock);
    reset = 1'b0; seed = s;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mlfsr = (s == 8'h00) ? 8'h01 : s;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({m0_resp_valid, m1_resp_valid, mem_en, mem_wen,
                              m0_req_ready, m1_req_ready}), 32'd0);
    check("rst_regs", mem_addr | mem_wdata | 32'(mem_wmask) | m0_rdata | m1_rdata, 32'd0);
  endtask

  // One complete transaction on master m; exp_d < 0 takes the delay from the model.
  task automatic do_txn(input bit m, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int hold, input bit raise_other, input int exp_d);
    int d, t, k, idx;
    logic [31:0] exp_rd, held;
    bit bad;
    idx = int'(addr[9:2]);
    d = (exp_d >= 0) ? exp_d : model_delay(mlfsr);
    exp_rd = wen ? 32'h0 : ref_mem[idx];
    @(negedge clock);
    set_req(m, wen, addr, wdata, wmask);
    set_rready(m, hold == 0);
    #1;
    k = 0;
    while (!get_ready(m) && k < 200) begin
      @(negedge clock); #1; k++;
    end
    check("req_ready", 32'(get_ready(m)), 32'd1);
    if (!get_ready(m)) begin
      set_valid(m, 1'b0);
      return;
    end
    t = cyc;
    mlfsr = lfsr_next(mlfsr);
    if (wen)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    @(negedge clock);
    set_valid(m, 1'b0);
    if (raise_other) set_valid(!m, 1'b1);
    bad = 1'b0;
    k = 0;
    while (mem_en !== 1'b1 && k < 400) begin
      #1; if (raise_other && get_ready(!m)) bad = 1'b1;
      @(negedge clock); k++;
    end
    check("mem_en_latency", 32'(cyc - t), 32'(2 + d));
    check("mem_wen", 32'(mem_wen), 32'(wen));
    check("mem_addr", mem_addr, addr);
    check("mem_wdata", mem_wdata, wdata);
    check("mem_wmask", 32'(mem_wmask), 32'(wmask));
    k = 0;
    while (get_rvalid(m) !== 1'b1 && k < 10) begin
      #1; if (raise_other && get_ready(!m)) bad = 1'b1;
      @(negedge clock); k++;
    end
    check("resp_latency", 32'(cyc - t), 32'(4 + d));
    check("rdata", get_rdata(m), exp_rd);
    check("other_resp_valid", 32'(get_rvalid(!m)), 32'd0);
    held = get_rdata(m);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock); #1;
      if (!get_rvalid(m) || get_rdata(m) !== held || get_rvalid(!m)) bad = 1'b1;
      if (raise_other && get_ready(!m)) bad = 1'b1;
    end
    set_rready(m, 1'b1);
    @(negedge clock); #1;
    check("resp_drop", 32'(get_rvalid(m)), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    if (raise_other) begin
      check("other_ready_after", 32'(get_ready(!m)), 32'd1);
      set_valid(!m, 1'b0);
    end
    check("hold_stable", 32'(bad), 32'd0);
    set_rready(m, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  seed;
    bit          m;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          exp_d;
  } vec_t;

  vec_t vt[6];

  initial begin
    int k, n, exp_m;
    vt[0] = '{8'hDA, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 8};
    vt[1] = '{8'h00, 1'b1, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 1};
    vt[2] = '{8'h15, 1'b0, 1'b1, 32'h8000_0008, 32'h1234_5678, 4'hF, 0};
    vt[3] = '{8'h14, 1'b1, 1'b0, 32'h8000_0008, 32'h0,         4'h0, 20};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 32'h8000_000C, 32'hCAFE_F00D, 4'hA, 3};
    vt[5] = '{8'hA8, 1'b1, 1'b0, 32'h8000_000C, 32'h0,         4'h0, 0};
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    @(negedge clock);
    fill = 1'b0;

    // First transaction after reset for a range of seeds, including d=0 and d=MAX.
    for (int i = 0; i < 6; i++) begin
      apply_reset(vt[i].seed);
      do_txn(vt[i].m, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask, 0, 1'b0, vt[i].exp_d);
    end

    // Back-to-back reads: 0xDA gives d=8, then 0xB5 gives d=13.
    apply_reset(8'hDA);
    do_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, 8);
    do_txn(1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, 1'b0, 13);

    // Partial-mask write by m1, then read-back of the merged word by m0.
    do_txn(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 1'b0, -1);
    do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, -1);
    check("merged_word", ref_mem[4], {pat(4)[31:16], 16'hBEEF});

    // Response back-pressure while the other master waits.
    do_txn(1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 5, 1'b1, -1);
    do_txn(1'b1, 1'b0, 32'h8000_0024, 32'h0, 4'h0, 2, 1'b0, -1);

    // Continuous requests from both masters alternate starting with m0.
    apply_reset(8'h3C);
    gq.delete(); rq.delete();
    rr_on = 1'b1;
    @(negedge clock);
    m0_wen = 1'b0; m1_wen = 1'b0;
    m0_addr = 32'h8000_0100; m1_addr = 32'h8000_0200;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    k = 0;
    while (rq.size() < 4 && k < 500) begin
      @(negedge clock); #2; k++;
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    repeat (3) @(negedge clock);
    rr_on = 1'b0;
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    check("rr_resp_count", 32'(rq.size()), 32'd4);
    check("rr_grant_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_m = i % 2;
      check("rr_grant_order", 32'((i < gq.size()) ? gq[i] : 9), 32'(exp_m));
      check("rr_resp_owner", 32'((i < rq.size()) ? rq[i] : 9), 32'(exp_m));
    end

    // Reset during DELAY abandons the transaction and restarts the LFSR.
    apply_reset(8'hDA);
    @(negedge clock);
    set_req(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    m0_resp_ready = 1'b1;
    #1;
    check("abort_req_ready", 32'(m0_req_ready), 32'd1);
    @(negedge clock);
    m0_req_valid = 1'b0;
    @(negedge clock);
    check("abort_busy_before", 32'(busy), 32'd1);
    apply_reset(8'hDA);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (m0_resp_valid || m1_resp_valid || mem_en) n++;
    end
    check("abort_no_resp", 32'(n), 32'd0);
    m0_resp_ready = 1'b0;
    do_txn(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b0, 8);

    // Random traffic against the model.
    apply_reset(8'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'h8000_0000 | (32'($urandom_range(0, 31)) << 2), 32'($urandom),
             4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, -1);
    end

    check("protocol_violations", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
